// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: segment patterns and
// the derivation of the slot divider and the PWM sub-phase length.
package seg7_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba patterns, entry 0 in the least significant slot.
    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_HEX_TABLE[nib];
    endfunction

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned scan_hz);
        return clk_hz / scan_hz;
    endfunction

    function automatic int unsigned calc_sub_len(input int unsigned div,
                                                 input int unsigned bright_w);
        return ((div >> bright_w) == 32'd0) ? 32'd1 : (div >> bright_w);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_bin_7seg.sv
// Hex nibble to active-low 7-segment pattern decoder.
module seg7_scan_ctrl_bin_7seg
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered frame data, a dead
// cycle after every slot change, PWM brightness and leading-zero suppression.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 32'd8,
    parameter int unsigned CLK_HZ     = 32'd100_000_000,
    parameter int unsigned SCAN_HZ    = 32'd1000,
    parameter int unsigned BRIGHT_W   = 32'd3
) (
    input  logic                    fpga_clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned DIV     = calc_div(CLK_HZ, SCAN_HZ);
    localparam int unsigned SUB_LEN = calc_sub_len(DIV, BRIGHT_W);
    localparam int unsigned PW      = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam int unsigned SW      = (SUB_LEN > 32'd1) ? $clog2(SUB_LEN) : 32'd1;
    localparam int unsigned IW      = (NUM_DIGITS > 32'd1) ? $clog2(NUM_DIGITS) : 32'd1;

    localparam logic [PW-1:0]       PRESC_MAX  = PW'(DIV - 32'd1);
    localparam logic [SW-1:0]       SUB_MAX    = SW'(SUB_LEN - 32'd1);
    localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = '1;

    logic [PW-1:0]           r_presc;
    logic [SW-1:0]           r_sub_cnt;
    logic [BRIGHT_W-1:0]     r_subph;
    logic [IW-1:0]           r_ptr;

    logic [4*NUM_DIGITS-1:0] r_shd_data;
    logic [NUM_DIGITS-1:0]   r_shd_en;
    logic [NUM_DIGITS-1:0]   r_shd_dp;
    logic [BRIGHT_W-1:0]     r_shd_bright;
    logic                    r_shd_blz;

    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_en;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [BRIGHT_W-1:0]     r_act_bright;
    logic                    r_act_blz;

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_found_hi;
    logic                    w_zero_run;
    logic                    w_pwm_on;
    logic [PW-1:0]           w_presc_nxt;
    logic [SW-1:0]           w_sub_cnt_nxt;
    logic [BRIGHT_W-1:0]     w_subph_nxt;
    logic [IW-1:0]           w_next_hi;
    logic [IW-1:0]           w_low_shd;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic [3:0]              w_cur_nib;
    logic [6:0]              w_cur_seg;

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_wrap = ~w_found_hi;

    // Slot timebase: prescaler plus a sub-phase counter that restarts each tick.
    always_comb begin
        w_presc_nxt   = '0;
        w_sub_cnt_nxt = '0;
        w_subph_nxt   = '0;
        if (w_tick) begin
            w_presc_nxt   = '0;
            w_sub_cnt_nxt = '0;
            w_subph_nxt   = '0;
        end else begin
            w_presc_nxt = r_presc + PW'(1'b1);
            if (r_sub_cnt == SUB_MAX) begin
                w_sub_cnt_nxt = '0;
                if (r_subph == BRIGHT_MAX) begin
                    w_subph_nxt = r_subph;
                end else begin
                    w_subph_nxt = r_subph + BRIGHT_W'(1'b1);
                end
            end else begin
                w_sub_cnt_nxt = r_sub_cnt + SW'(1'b1);
                w_subph_nxt   = r_subph;
            end
        end
    end

    // Next enabled digit above the pointer, and the first digit of the pending frame.
    always_comb begin
        w_found_hi = 1'b0;
        w_next_hi  = '0;
        w_low_shd  = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (r_act_en[i] && (i > int'(r_ptr))) begin
                w_found_hi = 1'b1;
                w_next_hi  = IW'(i);
            end else begin
                w_found_hi = w_found_hi;
                w_next_hi  = w_next_hi;
            end
            if (r_shd_en[i]) begin
                w_low_shd = IW'(i);
            end else begin
                w_low_shd = w_low_shd;
            end
        end
    end

    // A digit is a leading zero when it and every enabled digit above it are zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz_blank = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            if (r_act_en[i]) begin
                w_zero_run    = w_zero_run & (r_act_data[4*i +: 4] == 4'h0);
                w_lz_blank[i] = r_act_blz & w_zero_run;
            end else begin
                w_lz_blank[i] = 1'b0;
            end
        end
    end

    // One-hot-low anode pattern for the current pointer.
    always_comb begin
        w_an_sel        = '1;
        w_an_sel[r_ptr] = 1'b0;
    end

    assign w_cur_nib = r_act_data[{r_ptr, 2'b00} +: 4];
    assign w_pwm_on  = (w_subph_nxt <= r_act_bright);

    seg7_scan_ctrl_bin_7seg u_bin_7seg (
        .i_nib (w_cur_nib),
        .o_seg (w_cur_seg)
    );

    // Timebase and scan pointer; a wrap jumps to the first digit of the new frame.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_sub_cnt <= '0;
            r_subph   <= '0;
            r_ptr     <= '0;
        end else begin
            r_presc   <= w_presc_nxt;
            r_sub_cnt <= w_sub_cnt_nxt;
            r_subph   <= w_subph_nxt;
            if (w_tick) begin
                r_ptr <= w_wrap ? w_low_shd : w_next_hi;
            end else begin
                r_ptr <= r_ptr;
            end
        end
    end

    // Shadow captures on load; active takes the previous shadow only on a wrap tick.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shd_data   <= '0;
            r_shd_en     <= '1;
            r_shd_dp     <= '0;
            r_shd_bright <= BRIGHT_MAX;
            r_shd_blz    <= 1'b0;
            r_act_data   <= '0;
            r_act_en     <= '1;
            r_act_dp     <= '0;
            r_act_bright <= BRIGHT_MAX;
            r_act_blz    <= 1'b0;
        end else begin
            if (load) begin
                r_shd_data   <= digit_data;
                r_shd_en     <= digit_en;
                r_shd_dp     <= dp;
                r_shd_bright <= brightness;
                r_shd_blz    <= blank_lz;
            end else begin
                r_shd_data   <= r_shd_data;
                r_shd_en     <= r_shd_en;
                r_shd_dp     <= r_shd_dp;
                r_shd_bright <= r_shd_bright;
                r_shd_blz    <= r_shd_blz;
            end
            if (w_tick && w_wrap) begin
                r_act_data   <= r_shd_data;
                r_act_en     <= r_shd_en;
                r_act_dp     <= r_shd_dp;
                r_act_bright <= r_shd_bright;
                r_act_blz    <= r_shd_blz;
            end else begin
                r_act_data   <= r_act_data;
                r_act_en     <= r_act_en;
                r_act_dp     <= r_act_dp;
                r_act_bright <= r_act_bright;
                r_act_blz    <= r_act_blz;
            end
        end
    end

    // Output drive: dark on the cycle after a tick, then the current digit under PWM.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_tick & w_wrap;
            if (w_tick || !r_act_en[r_ptr]) begin
                an   <= '1;
                seg  <= SEG_BLANK;
                dp_n <= 1'b1;
            end else begin
                an   <= w_pwm_on ? w_an_sel : '1;
                seg  <= w_lz_blank[r_ptr] ? SEG_BLANK : w_cur_seg;
                dp_n <= ~r_act_dp[r_ptr];
            end
        end
    end

endmodule
